// File: rtl/bfb_align_acc.sv
// bfb_align_acc
// Consumer side of the block-floating-point product path. Each accepted beat
// carries an unsigned product mantissa plus shared-exponent metadata. The
// mantissa is pre-shifted by (d1+d2), aligned to the running block exponent
// and accumulated. On the last beat of a block the sum is normalized, then
// emitted as one mantissa/exponent pair over a valid/ready handshake.
//
// Optional feature: define BFB_ROUND_EN to round every right shift to the
// nearest value by adding the last shifted-out bit. Without it, right shifts
// truncate.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid & in_ready (IDLE/ACC only)
//   in_pp      unsigned product mantissa, MANT_W bits
//   in_emax    beat exponent
//   in_d1      pre-shift amount 1
//   in_d2      pre-shift amount 2
//   in_last    final beat of block
//   out_valid  result valid
//   out_ready  result consumed when out_valid & out_ready
//   out_mant   normalized block mantissa, ACC_W bits
//   out_exp    block exponent
//   out_ovf    sticky exponent-overflow flag for the block
module bfb_align_acc #(
  parameter int MANT_W = 8,
  parameter int EXP_W  = 4,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_pp,
  input  logic [EXP_W-1:0]  in_emax,
  input  logic [EXP_W-1:0]  in_d1,
  input  logic [EXP_W-1:0]  in_d2,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_ovf
);

  // Shift amounts carry one extra bit so d1+d2 cannot wrap.
  localparam int SH_W = EXP_W + 1;

  typedef enum logic [1:0] {IDLE, ACC, NORM, DONE} state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [EXP_W-1:0]   acc_exp, acc_exp_next;
  logic               ovf, ovf_next;

  logic               beat;
  logic               norm_done;
  logic [ACC_W-1:0]   pp_ext;
  logic [ACC_W-1:0]   m_in;
  logic               up;
  logic [ACC_W-1:0]   a_op, b_op;
  logic [EXP_W-1:0]   base_exp;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   half;
  logic [EXP_W:0]     inc;
  logic [EXP_W:0]     bumped;

  // Right shift with saturation to zero for large amounts; optionally rounds
  // by adding the last bit shifted out. With amt >= 1 the truncated value is
  // below 2^(ACC_W-1), so the rounding add can never overflow here.
  function automatic logic [ACC_W-1:0] shr(input logic [ACC_W-1:0] v,
                                           input logic [SH_W-1:0]  amt);
    logic [ACC_W-1:0] r;
`ifdef BFB_ROUND_EN
    logic [ACC_W-1:0] g;
`endif
    r = (32'(amt) >= ACC_W) ? '0 : (v >> amt);
`ifdef BFB_ROUND_EN
    g = v >> (amt - SH_W'(1));
    if (amt != '0 && 32'(amt) <= ACC_W)
      r = r + {{(ACC_W-1){1'b0}}, g[0]};
`endif
    return r;
  endfunction

  assign beat      = in_valid & in_ready;
  assign norm_done = (acc == '0) || acc[ACC_W-1] || (acc_exp == '0);
  assign pp_ext    = ACC_W'(in_pp) << (ACC_W - MANT_W);
  assign m_in      = shr(pp_ext, SH_W'(in_d1) + SH_W'(in_d2));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (beat) state_next = in_last ? NORM : ACC;
      ACC:  if (beat && in_last) state_next = NORM;
      NORM: if (norm_done) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = (state == IDLE) || (state == ACC);
  end

  // ---------------- datapath ----------------
  always_comb begin
    acc_next     = acc;
    acc_exp_next = acc_exp;
    ovf_next     = ovf;

    // Align the smaller-exponent operand to the larger exponent.
    up       = in_emax > acc_exp;
    a_op     = up ? shr(acc, SH_W'(in_emax - acc_exp)) : acc;
    b_op     = up ? m_in : shr(m_in, SH_W'(acc_exp - in_emax));
    base_exp = up ? in_emax : acc_exp;
    sum      = {1'b0, a_op} + {1'b0, b_op};

    half = sum[ACC_W:1];
    inc  = (EXP_W+1)'(1);
`ifdef BFB_ROUND_EN
    // Rounding the carry shift can itself carry out (sum all-ones); that is
    // renormalized as a second carry: mantissa 100..0, exponent +2.
    if (sum[0]) begin
      if (&half) begin
        half = {1'b1, {(ACC_W-1){1'b0}}};
        inc  = (EXP_W+1)'(2);
      end else begin
        half = half + ACC_W'(1);
      end
    end
`endif
    bumped = {1'b0, base_exp} + inc;

    case (state)
      IDLE: begin
        if (beat) begin
          acc_next     = m_in;
          acc_exp_next = in_emax;
          ovf_next     = 1'b0;
        end
      end
      ACC: begin
        if (beat) begin
          if (!sum[ACC_W]) begin
            acc_next     = sum[ACC_W-1:0];
            acc_exp_next = base_exp;
          end else if (bumped[EXP_W]) begin
            // Exponent cannot grow: saturate mantissa, flag overflow.
            acc_next     = '1;
            acc_exp_next = base_exp;
            ovf_next     = 1'b1;
          end else begin
            acc_next     = half;
            acc_exp_next = bumped[EXP_W-1:0];
          end
        end
      end
      NORM: begin
        if (acc == '0) begin
          acc_exp_next = '0;
        end else if (!norm_done) begin
          acc_next     = acc << 1;
          acc_exp_next = acc_exp - EXP_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_exp <= '0;
      ovf     <= 1'b0;
    end else begin
      acc     <= acc_next;
      acc_exp <= acc_exp_next;
      ovf     <= ovf_next;
    end
  end

  // Result registers are loaded on the final NORM step so they hold steady
  // for the whole DONE period, whatever the consumer does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_ovf   <= 1'b0;
    end else if (state == NORM && norm_done) begin
      out_valid <= 1'b1;
      out_mant  <= acc;
      out_exp   <= (acc == '0) ? '0 : acc_exp;
      out_ovf   <= ovf;
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bfb_align_acc.sv
module tb_bfb_align_acc;

  localparam int MANT_W = 8;
  localparam int EXP_W  = 4;
  localparam int ACC_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [MANT_W-1:0] in_pp = '0;
  logic [EXP_W-1:0]  in_emax = '0;
  logic [EXP_W-1:0]  in_d1 = '0;
  logic [EXP_W-1:0]  in_d2 = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic              out_ovf;

  bfb_align_acc #(.MANT_W(MANT_W), .EXP_W(EXP_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pp(in_pp),
    .in_emax(in_emax), .in_d1(in_d1), .in_d2(in_d2), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int pp;
    int emax;
    int d1;
    int d2;
  } beat_t;

  typedef struct {
    string name;
    int    nb;
    beat_t b0;
    beat_t b1;
    int    mant;
    int    ex;
    int    ovf;
    int    lat;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  beat_t blk[4];
  int    nblk;
  int    accept_cyc;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Right shift of a non-negative value; amounts above the accumulator
  // width give zero, optional round-to-nearest on the dropped bit.
  function automatic int rsh(input int x, input int n);
    int r;
    if (n > ACC_W) return 0;
    r = (n == ACC_W) ? 0 : (x >> n);
`ifdef BFB_ROUND_EN
    if (n >= 1) r += (x >> (n - 1)) & 1;
`endif
    return r;
  endfunction

  // Reference: plain integer arithmetic over the beats in blk[0..nblk-1].
  function automatic void model(output int mant, output int ex,
                                output int ov, output int k);
    int a, e, m, ne, s, t, inc;
    a  = rsh(blk[0].pp * 256, blk[0].d1 + blk[0].d2);
    e  = blk[0].emax;
    ov = 0;
    for (int i = 1; i < nblk; i++) begin
      m  = rsh(blk[i].pp * 256, blk[i].d1 + blk[i].d2);
      ne = (blk[i].emax > e) ? blk[i].emax : e;
      s  = rsh(a, ne - e) + rsh(m, ne - blk[i].emax);
      e  = ne;
      if (s > 65535) begin
        t   = rsh(s, 1);
        inc = 1;
        if (t > 65535) begin
          t   = rsh(t, 1);
          inc = 2;
        end
        if (e + inc > 15) begin
          a  = 65535;
          ov = 1;
        end else begin
          a = t;
          e = e + inc;
        end
      end else begin
        a = s;
      end
    end
    k = 0;
    if (a == 0) begin
      e = 0;
    end else begin
      while (a < 32768 && e > 0) begin
        a = a * 2;
        e = e - 1;
        k++;
      end
    end
    mant = a;
    ex   = e;
  endfunction

  function automatic beat_t mkb(input int pp, input int emax, input int d1, input int d2);
    beat_t b;
    b.pp = pp; b.emax = emax; b.d1 = d1; b.d2 = d2;
    return b;
  endfunction

  function automatic vec_t mkv(input string name, input int nb, input beat_t b0, input beat_t b1,
                               input int mant, input int ex, input int ovf, input int lat);
    vec_t v;
    v.name = name; v.nb = nb; v.b0 = b0; v.b1 = b1;
    v.mant = mant; v.ex = ex; v.ovf = ovf; v.lat = lat;
    return v;
  endfunction

  // Drive blk[] with up to gap_max idle cycles before each beat.
  // accept_cyc is the cycle in which the last beat is accepted.
  task automatic drive_beats(input int gap_max);
    int n;
    for (int i = 0; i < nblk; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_pp    = MANT_W'(blk[i].pp);
      in_emax  = EXP_W'(blk[i].emax);
      in_d1    = EXP_W'(blk[i].d1);
      in_d2    = EXP_W'(blk[i].d2);
      in_last  = (i == nblk - 1);
      n = 0;
      while (!in_ready && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 200) check("in_ready_timeout", 0, 1);
      accept_cyc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_out(output int mant, output int ex, output int ov, output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      mant = -1; ex = -1; ov = -1; lat = -1;
    end else begin
      mant = int'(out_mant);
      ex   = int'(out_exp);
      ov   = int'(out_ovf);
      lat  = cyc - accept_cyc;
    end
  endtask

  task automatic release_out(input int hold);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handshake_clears_valid", int'(out_valid), 0);
  endtask

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mant, ex, ov, lat, emant, eex, eov, k;

    vecs[0] = mkv("carry",  2, mkb(8'h80, 5, 0, 0), mkb(8'h80, 5, 0, 0), 16'h8000, 6, 0, 2);
    vecs[1] = mkv("norm",   1, mkb(8'h40, 3, 1, 0), mkb(0, 0, 0, 0),     16'h8000, 1, 0, 4);
    vecs[2] = mkv("align",  2, mkb(8'h80, 2, 0, 0), mkb(8'h80, 4, 0, 0), 16'hA000, 4, 0, 2);
    vecs[3] = mkv("shift16",2, mkb(8'h7F, 3, 8, 8), mkb(8'h80, 3, 0, 0), 16'h8000, 3, 0, 2);
    vecs[4] = mkv("ovf",    2, mkb(8'hFF,15, 0, 0), mkb(8'hFF,15, 0, 0), 16'hFFFF,15, 1, 2);
    vecs[5] = mkv("zero",   1, mkb(8'h00, 7, 0, 0), mkb(0, 0, 0, 0),     16'h0000, 0, 0, 2);
    vecs[6] = mkv("exp0",   1, mkb(8'h01, 1, 0, 0), mkb(0, 0, 0, 0),     16'h0200, 0, 0, 3);
`ifdef BFB_ROUND_EN
    vecs[7] = mkv("round",  1, mkb(8'h03, 0, 9, 0), mkb(0, 0, 0, 0),     16'h0002, 0, 0, 2);
`else
    vecs[7] = mkv("round",  1, mkb(8'h03, 0, 9, 0), mkb(0, 0, 0, 0),     16'h0001, 0, 0, 2);
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_mant",  int'(out_mant), 0);
    check("rst_out_exp",   int'(out_exp), 0);
    check("rst_out_ovf",   int'(out_ovf), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready",  int'(in_ready), 1);

    // Directed table
    foreach (vecs[i]) begin
      nblk = vecs[i].nb;
      blk[0] = vecs[i].b0;
      blk[1] = vecs[i].b1;
      drive_beats(0);
      wait_out(mant, ex, ov, lat);
      $display("vec %s: mant=0x%04h exp=%0d ovf=%0d lat=%0d", vecs[i].name, mant, ex, ov, lat);
      check({vecs[i].name, "_mant"}, mant, vecs[i].mant);
      check({vecs[i].name, "_exp"},  ex,   vecs[i].ex);
      check({vecs[i].name, "_ovf"},  ov,   vecs[i].ovf);
      check({vecs[i].name, "_lat"},  lat,  vecs[i].lat);
      check({vecs[i].name, "_busy"}, int'(in_ready), 0);
      release_out(1);
    end

    // Backpressure: result held, input refused until the handshake
    nblk = 2;
    blk[0] = mkb(8'h80, 5, 0, 0);
    blk[1] = mkb(8'h80, 5, 0, 0);
    drive_beats(0);
    wait_out(mant, ex, ov, lat);
    in_valid = 1'b1; in_pp = 8'h40; in_emax = 4'd3; in_d1 = 4'd1; in_d2 = 4'd0; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_mant",  int'(out_mant), 16'h8000);
      check("bp_out_exp",   int'(out_exp), 6);
      check("bp_in_ready",  int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_valid_drop", int'(out_valid), 0);
    check("bp_idle_ready", int'(in_ready), 1);
    accept_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    wait_out(mant, ex, ov, lat);
    $display("bp second block: mant=0x%04h exp=%0d ovf=%0d lat=%0d", mant, ex, ov, lat);
    check("bp2_mant", mant, 16'h8000);
    check("bp2_exp",  ex, 1);
    check("bp2_lat",  lat, 4);
    release_out(0);

    // Reset in the middle of a block
    in_valid = 1'b1; in_pp = 8'hFF; in_emax = 4'd9; in_d1 = 4'd0; in_d2 = 4'd0; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_mant",  int'(out_mant), 0);
    check("midrst_out_exp",   int'(out_exp), 0);
    check("midrst_out_ovf",   int'(out_ovf), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", int'(in_ready), 1);
    nblk = 1;
    blk[0] = mkb(8'h40, 3, 1, 0);
    drive_beats(0);
    wait_out(mant, ex, ov, lat);
    $display("post-reset block: mant=0x%04h exp=%0d ovf=%0d lat=%0d", mant, ex, ov, lat);
    check("midrst_next_mant", mant, 16'h8000);
    check("midrst_next_exp",  ex, 1);
    check("midrst_next_ovf",  ov, 0);
    release_out(0);

    // Randomized blocks against the reference model
    for (int t = 0; t < 60; t++) begin
      nblk = $urandom_range(4, 1);
      for (int i = 0; i < nblk; i++)
        blk[i] = mkb($urandom_range(255, 0), $urandom_range(15, 0),
                     $urandom_range(9, 0), $urandom_range(9, 0));
      model(emant, eex, eov, k);
      drive_beats(2);
      wait_out(mant, ex, ov, lat);
      $display("rnd %0d: beats=%0d mant=0x%04h exp=%0d ovf=%0d lat=%0d", t, nblk, mant, ex, ov, lat);
      check("rnd_mant", mant, emant);
      check("rnd_exp",  ex, eex);
      check("rnd_ovf",  ov, eov);
      check("rnd_lat",  lat, 2 + k);
      release_out($urandom_range(3, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
